mux_n_arb_reg: RTL and testbench
================================

Name: mux_n_arb_reg

Overview:
- Parametrised N-input, WIDTH-bit data selector with a valid/ready handshake on every input and on the output, plus one registered output stage.
- Two selection modes:
  - Direct: an external select chooses the channel, as in the existing 4:1 wide mux.
  - Round-robin: fair arbitration among the valid inputs.
- Used wherever several producers share one datapath, e.g. writeback, memory request or bus merge points.

Parameters:
- WIDTH, 32, data bits per channel (>=1).
- NUM_IN, 4, number of input channels (>=2; need not be a power of 2).
- SEL_W, $clog2(NUM_IN), width of select and source-id fields (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready (combinational).
- sel  input  SEL_W  channel choice in direct mode.
- rr_en  input  1  0 = direct mode, 1 = round-robin mode.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered valid.
- out_src  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low; all state is cleared immediately on rst_n low, independent of clk.
- Reset values:
  - out_valid = 0, out_data = 0, out_src = 0.
  - Internal last-grant pointer last = NUM_IN-1, so channel 0 has first priority after reset.
- Load enable: load_en = !out_valid || out_ready (combinational).
- Grant, direct mode (rr_en=0):
  - grant = sel; grant_vld = in_valid[sel].
  - If sel >= NUM_IN, grant_vld = 0 (no channel served).
- Grant, round-robin mode (rr_en=1):
  - Scan channels starting at (last+1) mod NUM_IN, wrapping upward.
  - grant = first channel with in_valid set; grant_vld = |in_valid.
- Ready: in_ready[i] = load_en && grant_vld && (grant == i).
  - At most one in_ready is high per cycle.
  - in_ready may depend on in_valid; upstream must not make in_valid depend on in_ready.
- Transfer into the block occurs on in_valid[i] && in_ready[i].
- Clock edge with load_en=1:
  - out_valid <= grant_vld.
  - If grant_vld: out_data <= selected channel's data, out_src <= grant.
  - If !grant_vld: out_data and out_src hold their values.
- Clock edge with load_en=0 (out_valid=1, out_ready=0): all output registers hold (stall); no in_ready is asserted.
- Pointer update: last <= grant only on an input transfer with rr_en=1. Direct-mode transfers leave last unchanged.
- Latency and throughput:
  - Latency is exactly 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 transfer/cycle when out_ready is held high.
- Boundary conditions:
  - Simultaneous output handshake and new input transfer in the same cycle: the new word replaces the old one with no bubble.
  - All in_valid low in round-robin mode: no grant, and last is unchanged.
  - Wrap: last=NUM_IN-1 restarts the scan at channel 0.
  - Mode change mid-stream: takes effect on the next combinational grant; last is preserved across mode switches.
  - rr_en and sel may change while stalled; they affect only the next load.
  - Reset mid-operation: any word held in the output register is discarded; out_valid=0 immediately, asynchronously.
- Data integrity: no data is duplicated or dropped; each accepted input yields exactly one output handshake.

Test Plan:
1. Reset + direct mode: WIDTH=32, NUM_IN=4; drive rr_en=0, sel=2, in_valid=4'b0110, ch2=0xDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xDEADBEEF, out_src=2.
2. Round-robin fairness: rr_en=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, one word per cycle, no bubbles.
3. Backpressure: out_ready=0 after the first word (ch0 data 0x11) -> out_data stays 0x11, in_ready=0 for 5 cycles; release out_ready -> 0x11 handshakes and the next grant is channel 1.
4. Sparse and wrap: rr_en=1, last=3 after reset sequence, in_valid=4'b1010 -> grants 1, 3, 1, 3; with NUM_IN=3 and sel=3 in direct mode -> in_ready=0, out_valid=0.
5. Async reset mid-stream: assert rst_n low between clock edges while out_valid=1 -> out_valid=0, out_data=0 at once; after release, the first round-robin grant goes to channel 0.
6. Mode switch: rr_en 1->0 with last=1, sel=3, in_valid=4'b1111 -> grant 3; switch back to rr_en=1 -> next grant 2.

Source files
------------

// File: rtl/mux_n_arb_reg_if.sv
// rtl/mux_n_arb_reg_if.sv - handshake bundle for the N-input arbitrated register mux
//
// Purpose: groups the per-channel input handshake, mode controls and the
//          registered output handshake of mux_n_arb_reg.
// Signals:
//   in_data   NUM_IN*WIDTH  flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  NUM_IN        per-channel valid
//   in_ready  NUM_IN        per-channel ready (driven by the mux)
//   sel       SEL_W         direct-mode channel choice
//   rr_en     1             0 = direct, 1 = round-robin
//   out_data  WIDTH         registered selected data
//   out_valid 1             registered valid
//   out_src   SEL_W         channel that produced out_data
//   out_ready 1             downstream ready
// Modports: slave = the mux, master = the producer/consumer side.
interface mux_n_arb_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic                    rr_en;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic [SEL_W-1:0]        out_src;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, sel, rr_en, out_ready,
    output in_ready, out_data, out_valid, out_src
  );

  modport master (
    output in_data, in_valid, sel, rr_en, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/mux_n_arb_reg.sv
// rtl/mux_n_arb_reg.sv - N-input valid/ready selector with direct or round-robin grant and one output register
//
// Purpose: merges NUM_IN producers onto one registered WIDTH-bit output.
//          Direct mode serves the channel named by sel; round-robin mode
//          serves the next valid channel after the last one granted.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_n_arb_reg_if.slave (in_data/in_valid/in_ready, sel, rr_en,
//          out_data/out_valid/out_src/out_ready)
module mux_n_arb_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_n_arb_reg_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] rr_grant;
  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;
  logic             hi_found;
  logic             lo_found;
  logic             dir_vld;
  logic             grant_vld;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;
  logic [NUM_IN-1:0] ready_vec;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_src_q;

  // The output register can take a new word when empty or being drained.
  assign load_en = !out_valid_q || bus.out_ready;

  // Direct mode: a select beyond NUM_IN-1 matches no channel, so dir_vld stays 0.
  always_comb begin
    dir_vld = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.sel == SEL_W'(i)) dir_vld = bus.in_valid[i];
    end
  end

  // Round-robin: lowest valid channel above last wins; otherwise wrap to the
  // lowest valid channel overall. Descending scan leaves the lowest match.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = SEL_W'(i);
        if (SEL_W'(i) > last) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end
      end
    end
    rr_grant = hi_found ? hi_idx : lo_idx;
  end

  assign grant     = bus.rr_en ? rr_grant : bus.sel;
  assign grant_vld = bus.rr_en ? lo_found : dir_vld;
  assign xfer      = load_en && grant_vld;

  always_comb begin
    grant_data = '0;
    ready_vec  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data   = bus.in_data[i*WIDTH +: WIDTH];
        ready_vec[i] = xfer;
      end
    end
  end

  assign bus.in_ready = ready_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      last        <= SEL_W'(NUM_IN - 1);
    end else begin
      if (load_en) begin
        out_valid_q <= grant_vld;
        if (grant_vld) begin
          out_data_q <= grant_data;
          out_src_q  <= grant;
        end
      end
      // Only round-robin transfers advance fairness history.
      if (xfer && bus.rr_en) last <= grant;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_mux_n_arb_reg.sv
// tb/tb_mux_n_arb_reg.sv - scoreboard bench for mux_n_arb_reg
module tb_mux_n_arb_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_n_arb_reg_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
  mux_n_arb_reg_if #(.WIDTH(8),  .NUM_IN(3)) bus3 ();

  mux_n_arb_reg #(.WIDTH(32), .NUM_IN(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  mux_n_arb_reg #(.WIDTH(8),  .NUM_IN(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [33:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {30'd0, bus4.out_src, bus4.out_data}, 64'hDEAD);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("out_data", 64'(bus4.out_data), 64'(e[31:0]));
        chk("out_src", 64'(bus4.out_src), 64'(e[33:32]));
      end
    end
  end

  task automatic set_ch(input int i, input logic [31:0] d);
    bus4.in_data[i*32 +: 32] = d;
  endtask

  // Called at posedge+1 after inputs are driven; checks in_ready, records the
  // expected word if a transfer is due, then advances to the next posedge+1.
  task automatic tick(input logic [3:0] exp_rdy, input bit push,
                      input logic [31:0] d, input logic [1:0] s);
    #3;
    chk("in_ready", 64'(bus4.in_ready), 64'(exp_rdy));
    if (push) exp_q.push_back({s, d});
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus4.in_data = '0; bus4.in_valid = '0; bus4.sel = '0; bus4.rr_en = 1'b0; bus4.out_ready = 1'b0;
    bus3.in_data = 24'h332211; bus3.in_valid = 3'b111; bus3.sel = 2'd3; bus3.rr_en = 1'b0; bus3.out_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_out_valid", 64'(bus4.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus4.out_data), 64'd0);
    chk("rst_out_src", 64'(bus4.out_src), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: direct mode, sel=2
    set_ch(0, 32'h0000_00C0); set_ch(1, 32'h0000_00C1); set_ch(2, 32'hDEADBEEF); set_ch(3, 32'h0000_00C3);
    bus4.rr_en = 1'b0; bus4.sel = 2'd2; bus4.in_valid = 4'b0110; bus4.out_ready = 1'b1;
    tick(4'b0100, 1, 32'hDEADBEEF, 2'd2);
    bus4.in_valid = 4'b0000;
    tick(4'b0000, 0, 32'd0, 2'd0);

    // 2: round-robin fairness, last still 3 since direct mode does not move it
    for (int i = 0; i < 4; i++) set_ch(i, 32'hA0 + 32'(i));
    bus4.rr_en = 1'b1; bus4.in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) tick(4'(1 << (k % 4)), 1, 32'hA0 + 32'(k % 4), 2'(k % 4));
    bus4.in_valid = 4'b0000;
    tick(4'b0000, 0, 32'd0, 2'd0);

    // 3: backpressure
    set_ch(0, 32'h11); set_ch(1, 32'h22); set_ch(2, 32'h33); set_ch(3, 32'h44);
    bus4.in_valid = 4'b1111;
    tick(4'b0001, 1, 32'h11, 2'd0);
    bus4.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("stall_valid", 64'(bus4.out_valid), 64'd1);
      chk("stall_data", 64'(bus4.out_data), 64'h11);
      #1;
      chk("stall_ready", 64'(bus4.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus4.out_ready = 1'b1;
    tick(4'b0010, 1, 32'h22, 2'd1);
    bus4.in_valid = 4'b0000;
    tick(4'b0000, 0, 32'd0, 2'd0);

    // 4: sparse + wrap after a reset pulse (last back to 3)
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus4.in_valid = 4'b1010;
    tick(4'b0010, 1, 32'h22, 2'd1);
    tick(4'b1000, 1, 32'h44, 2'd3);
    tick(4'b0010, 1, 32'h22, 2'd1);
    tick(4'b1000, 1, 32'h44, 2'd3);
    chk("n3_sel3_ready", 64'(bus3.in_ready), 64'd0);
    chk("n3_sel3_valid", 64'(bus3.out_valid), 64'd0);
    bus4.in_valid = 4'b0000;
    tick(4'b0000, 0, 32'd0, 2'd0);

    // 5: async reset with a word held; last moves to 0 then is reset to 3
    bus4.in_valid = 4'b1111;
    tick(4'b0001, 0, 32'd0, 2'd0);
    bus4.in_valid = 4'b0000; bus4.out_ready = 1'b0;
    #2;
    chk("pre_rst_valid", 64'(bus4.out_valid), 64'd1);
    chk("pre_rst_data", 64'(bus4.out_data), 64'h11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus4.out_valid), 64'd0);
    chk("async_rst_data", 64'(bus4.out_data), 64'd0);
    chk("async_rst_src", 64'(bus4.out_src), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
    tick(4'b0001, 1, 32'h11, 2'd0);

    // 6: mode switch with last preserved
    tick(4'b0010, 1, 32'h22, 2'd1);
    bus4.rr_en = 1'b0; bus4.sel = 2'd3;
    tick(4'b1000, 1, 32'h44, 2'd3);
    bus4.rr_en = 1'b1;
    tick(4'b0100, 1, 32'h33, 2'd2);
    bus4.in_valid = 4'b0000;
    tick(4'b0000, 0, 32'd0, 2'd0);
    tick(4'b0000, 0, 32'd0, 2'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    #20;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
